// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage: opcode values, ALU one-hot bit
// indices, load/store and jump encodings, the decoded-bundle struct, the skid
// buffer state type, and the combinational decode() function.
package decode_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;

  // Bit positions within the one-hot alu_op field.
  localparam int unsigned AluAdd  = 0;
  localparam int unsigned AluSub  = 1;
  localparam int unsigned AluSll  = 2;
  localparam int unsigned AluSlt  = 3;
  localparam int unsigned AluSltu = 4;
  localparam int unsigned AluXor  = 5;
  localparam int unsigned AluSrl  = 6;
  localparam int unsigned AluSra  = 7;
  localparam int unsigned AluOr   = 8;
  localparam int unsigned AluAnd  = 9;

  localparam logic [1:0] JNone = 2'b00;
  localparam logic [1:0] JJal  = 2'b01;
  localparam logic [1:0] JJalr = 2'b10;

  // ls_op = {store, unsigned, size[1:0]}
  localparam logic [1:0] LsSizeB = 2'b00;
  localparam logic [1:0] LsSizeH = 2'b01;
  localparam logic [1:0] LsSizeW = 2'b10;

  typedef struct packed {
    logic        illegal;
    logic        alu_src_imm;
    logic        auipc;
    logic        lui;
    logic [3:0]  mdu_op;
    logic        b_en;
    logic [2:0]  b_op;
    logic [1:0]  j_op;
    logic        ls_en;
    logic [3:0]  ls_op;
    logic [9:0]  alu_op;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
  } decoded_t;

  localparam int unsigned DecW = $bits(decoded_t);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} skid_state_e;

  // funct3 -> one-hot ALU op; alt picks sub/sra over add/srl.
  function automatic logic [9:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [9:0] op;
    op = '0;
    case (f3)
      3'b000:  op[alt ? AluSub : AluAdd] = 1'b1;
      3'b001:  op[AluSll] = 1'b1;
      3'b010:  op[AluSlt] = 1'b1;
      3'b011:  op[AluSltu] = 1'b1;
      3'b100:  op[AluXor] = 1'b1;
      3'b101:  op[alt ? AluSra : AluSrl] = 1'b1;
      3'b110:  op[AluOr] = 1'b1;
      default: op[AluAnd] = 1'b1;
    endcase
    return op;
  endfunction

  function automatic decoded_t decode(input logic [31:0] inst, input logic en_m);
    decoded_t    d;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    opcode = inst[6:0];
    f3     = inst[14:12];
    f7     = inst[31:25];
    // Pure slicing plus sign extension from inst[31]; no adders.
    imm_i  = {{20{inst[31]}}, inst[31:20]};
    imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u  = {inst[31:12], 12'b0};
    imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    d = '0;
    case (opcode)
      OpLui: begin
        d.rd  = inst[11:7];
        d.imm = imm_u;
        d.lui = 1'b1;
      end
      OpAuipc: begin
        d.rd             = inst[11:7];
        d.imm            = imm_u;
        d.auipc          = 1'b1;
        d.alu_op[AluAdd] = 1'b1;
      end
      OpJal: begin
        d.rd             = inst[11:7];
        d.imm            = imm_j;
        d.j_op           = JJal;
        d.alu_op[AluAdd] = 1'b1;
      end
      OpJalr: begin
        d.rd             = inst[11:7];
        d.rs1            = inst[19:15];
        d.imm            = imm_i;
        d.j_op           = JJalr;
        d.alu_op[AluAdd] = 1'b1;
        d.illegal        = (f3 != 3'b000);
      end
      OpBranch: begin
        d.rs1     = inst[19:15];
        d.rs2     = inst[24:20];
        d.imm     = imm_b;
        d.b_en    = 1'b1;
        d.b_op    = f3;
        d.illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OpLoad: begin
        d.rd             = inst[11:7];
        d.rs1            = inst[19:15];
        d.imm            = imm_i;
        d.ls_en          = 1'b1;
        d.ls_op          = {1'b0, f3[2], f3[1:0]};
        d.alu_op[AluAdd] = 1'b1;
        d.illegal        = (f3[1:0] == 2'b11) || (f3 == 3'b110);
      end
      OpStore: begin
        d.rs1            = inst[19:15];
        d.rs2            = inst[24:20];
        d.imm            = imm_s;
        d.ls_en          = 1'b1;
        d.ls_op          = {1'b1, 1'b0, f3[1:0]};
        d.alu_op[AluAdd] = 1'b1;
        d.illegal        = f3[2] || (f3[1:0] == 2'b11);
      end
      OpOpImm: begin
        d.rd          = inst[11:7];
        d.rs1         = inst[19:15];
        d.imm         = imm_i;
        d.alu_src_imm = 1'b1;
        d.alu_op      = alu_from_f3(f3, (f3 == 3'b101) && inst[30]);
        if (f3 == 3'b001) begin
          d.illegal = (f7 != 7'b0);
        end else if (f3 == 3'b101) begin
          d.illegal = ({inst[31], inst[29:25]} != 6'b0);
        end
      end
      OpOp: begin
        d.rd  = inst[11:7];
        d.rs1 = inst[19:15];
        d.rs2 = inst[24:20];
        if (f7 == 7'b0000000) begin
          d.alu_op = alu_from_f3(f3, 1'b0);
        end else if (f7 == 7'b0100000) begin
          d.alu_op  = alu_from_f3(f3, 1'b1);
          d.illegal = (f3 != 3'b000) && (f3 != 3'b101);
        end else if (f7 == 7'b0000001) begin
          d.mdu_op  = {1'b1, f3};
          d.illegal = !en_m;
        end else begin
          d.illegal = 1'b1;
        end
      end
      default: d.illegal = 1'b1;
    endcase

    // Illegal encodings carry no op fields, only the flag.
    if (d.illegal) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_skid_buffer.sv
// Valid/ready pipeline register with optional second (skid) entry.
// Ports: clk, rst (async, active high), flush; in_valid/in_ready/in_data upstream;
// out_valid/out_ready/out_data downstream. W sets payload width; SKID=1 gives a
// registered in_ready and full throughput, SKID=0 a single entry with
// in_ready = !out_valid | out_ready.
module skid_buffer
  import decode_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter bit          SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic [W-1:0] out_q, skid_q;
  logic        accept, drain;
  logic        load_out, load_skid, sel_skid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next state and datapath enables
  always_comb begin
    accept    = in_valid && in_ready && !flush;
    drain     = out_valid && out_ready;
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    sel_skid  = 1'b0;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d  = StOne;
          load_out = 1'b1;
        end
      end
      StOne: begin
        if (accept && drain) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_d   = StTwo;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (drain) begin
          state_d  = StOne;
          load_out = 1'b1;
          sel_skid = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush wins over accept; a concurrent drain has already been seen downstream.
    if (flush) begin
      state_d   = StEmpty;
      load_out  = 1'b0;
      load_skid = 1'b0;
    end
    in_ready_d = (state_d != StTwo);
  end

  // Outputs
  always_comb begin
    out_valid = (state_q != StEmpty);
    in_ready  = SKID ? in_ready_q : ((state_q == StEmpty) || out_ready);
    out_data  = out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out) begin
        out_q <= sel_skid ? skid_q : in_data;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage between fetch and execute.
// Ports: clk, rst (async, active high), flush; upstream in_valid/in_ready with
// in_pc/in_inst; downstream out_valid/out_ready with the decoded bundle
// (out_pc, register indices, immediate, op fields, class flags, out_illegal).
// Decode is combinational on in_inst and captured, with the PC, in skid_buffer.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned PC_W = 32,
  parameter bit          EN_M = 1'b0,
  parameter bit          SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output logic [9:0]      out_alu_op,
  output logic [3:0]      out_ls_op,
  output logic            out_ls_en,
  output logic [1:0]      out_j_op,
  output logic [2:0]      out_b_op,
  output logic            out_b_en,
  output logic [3:0]      out_mdu_op,
  output logic            out_lui,
  output logic            out_auipc,
  output logic            out_alu_src_imm,
  output logic            out_illegal
);

  localparam int unsigned PayW = PC_W + DecW;

  decoded_t        dec_in, dec_out;
  logic [PayW-1:0] in_payload, out_payload;

  assign dec_in     = decode(in_inst, EN_M);
  assign in_payload = {in_pc, dec_in};

  skid_buffer #(
    .W    (PayW),
    .SKID (SKID)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign out_pc          = out_payload[PayW-1:DecW];
  assign dec_out         = out_payload[DecW-1:0];
  assign out_rs1         = dec_out.rs1;
  assign out_rs2         = dec_out.rs2;
  assign out_rd          = dec_out.rd;
  assign out_imm         = dec_out.imm;
  assign out_alu_op      = dec_out.alu_op;
  assign out_ls_op       = dec_out.ls_op;
  assign out_ls_en       = dec_out.ls_en;
  assign out_j_op        = dec_out.j_op;
  assign out_b_op        = dec_out.b_op;
  assign out_b_en        = dec_out.b_en;
  assign out_mdu_op      = dec_out.mdu_op;
  assign out_lui         = dec_out.lui;
  assign out_auipc       = dec_out.auipc;
  assign out_alu_src_imm = dec_out.alu_src_imm;
  assign out_illegal     = dec_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an EN_M=0 instance and an EN_M=1 instance
// share all inputs; expected values are hand-computed from the encodings.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [9:0]  out_alu_op;
  logic [3:0]  out_ls_op, out_mdu_op;
  logic        out_ls_en, out_b_en, out_lui, out_auipc, out_alu_src_imm, out_illegal;
  logic [1:0]  out_j_op;
  logic [2:0]  out_b_op;

  logic        m_in_ready, m_out_valid;
  logic [31:0] m_out_pc, m_out_imm;
  logic [4:0]  m_out_rs1, m_out_rs2, m_out_rd;
  logic [9:0]  m_out_alu_op;
  logic [3:0]  m_out_ls_op, m_out_mdu_op;
  logic        m_out_ls_en, m_out_b_en, m_out_lui, m_out_auipc, m_out_alu_src_imm;
  logic        m_out_illegal;
  logic [1:0]  m_out_j_op;
  logic [2:0]  m_out_b_op;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage #(.PC_W(32), .EN_M(1'b0), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_alu_op(out_alu_op), .out_ls_op(out_ls_op),
    .out_ls_en(out_ls_en), .out_j_op(out_j_op), .out_b_op(out_b_op), .out_b_en(out_b_en),
    .out_mdu_op(out_mdu_op), .out_lui(out_lui), .out_auipc(out_auipc),
    .out_alu_src_imm(out_alu_src_imm), .out_illegal(out_illegal)
  );

  decode_stage #(.PC_W(32), .EN_M(1'b1), .SKID(1'b1)) dut_m (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_pc(m_out_pc), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_rd(m_out_rd),
    .out_imm(m_out_imm), .out_alu_op(m_out_alu_op), .out_ls_op(m_out_ls_op),
    .out_ls_en(m_out_ls_en), .out_j_op(m_out_j_op), .out_b_op(m_out_b_op),
    .out_b_en(m_out_b_en), .out_mdu_op(m_out_mdu_op), .out_lui(m_out_lui),
    .out_auipc(m_out_auipc), .out_alu_src_imm(m_out_alu_src_imm),
    .out_illegal(m_out_illegal)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
  endtask

  initial begin
    // Async reset: outputs clear before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_pc", out_pc, 0);
    check_eq("rst_out_imm", out_imm, 0);
    check_eq("rst_out_alu_op", out_alu_op, 0);
    tick();
    tick();
    rst = 1'b0;

    // Streaming with out_ready=1: one bundle per cycle.
    out_ready = 1'b1;
    offer(32'h100, 32'h401101B3);                          // sub x3,x2,x1
    tick();
    check_eq("sub_valid", out_valid, 1);
    check_eq("sub_pc", out_pc, 32'h100);
    check_eq("sub_rs1", out_rs1, 2);
    check_eq("sub_rs2", out_rs2, 1);
    check_eq("sub_rd", out_rd, 3);
    check_eq("sub_alu", out_alu_op, 10'h002);
    check_eq("sub_imm", out_imm, 0);
    check_eq("sub_illegal", out_illegal, 0);
    offer(32'h104, 32'h8760EC93);                          // ori x25,x1,-1930
    tick();
    check_eq("ori_in_ready", in_ready, 1);
    check_eq("ori_rs1", out_rs1, 1);
    check_eq("ori_rd", out_rd, 25);
    check_eq("ori_imm", out_imm, 32'hFFFFF876);
    check_eq("ori_alu", out_alu_op, 10'h100);
    check_eq("ori_src_imm", out_alu_src_imm, 1);
    offer(32'h108, 32'hBF45FCB7);                          // lui x25,0xBF45F
    tick();
    check_eq("lui_rd", out_rd, 25);
    check_eq("lui_imm", out_imm, 32'hBF45F000);
    check_eq("lui_flag", out_lui, 1);
    check_eq("lui_rs1", out_rs1, 0);
    offer(32'h10C, 32'hEA1D6163);                          // bltu x26,x1,-2398
    tick();
    check_eq("bltu_rs1", out_rs1, 26);
    check_eq("bltu_rs2", out_rs2, 1);
    check_eq("bltu_b_en", out_b_en, 1);
    check_eq("bltu_b_op", out_b_op, 3'b110);
    check_eq("bltu_imm", out_imm, 32'hFFFFF6A2);
    check_eq("bltu_rd", out_rd, 0);
    offer(32'h110, 32'h00000000);                          // opcode 0000000
    tick();
    check_eq("zero_illegal", out_illegal, 1);
    check_eq("zero_pc", out_pc, 32'h110);
    check_eq("zero_alu", out_alu_op, 0);
    offer(32'h114, 32'h00812283);                          // lw x5,8(x2)
    tick();
    check_eq("lw_ls", {out_ls_en, out_ls_op}, 5'b1_0010);
    check_eq("lw_imm", out_imm, 8);
    check_eq("lw_alu", out_alu_op, 10'h001);
    offer(32'h118, 32'h00512623);                          // sw x5,12(x2)
    tick();
    check_eq("sw_ls", {out_ls_en, out_ls_op}, 5'b1_1010);
    check_eq("sw_imm", out_imm, 12);
    check_eq("sw_rs2", out_rs2, 5);
    offer(32'h11C, 32'h4030D093);                          // srai x1,x1,3
    tick();
    check_eq("srai_alu", out_alu_op, 10'h080);
    check_eq("srai_illegal", out_illegal, 0);
    offer(32'h120, 32'h02009093);                          // slli with inst[25]=1
    tick();
    check_eq("slli_bad_illegal", out_illegal, 1);
    offer(32'h124, 32'h02208033);                          // mul x0,x1,x2
    tick();
    check_eq("mul_m0_illegal", out_illegal, 1);
    check_eq("mul_m0_mdu", out_mdu_op, 0);
    check_eq("mul_m1_illegal", m_out_illegal, 0);
    check_eq("mul_m1_mdu", m_out_mdu_op, 4'b1000);
    check_eq("mul_m1_rs2", m_out_rs2, 2);
    in_valid = 1'b0;
    tick();
    check_eq("drain_empty", out_valid, 0);

    // Back-pressure: three back-to-back offers with out_ready low.
    out_ready = 1'b0;
    offer(32'h200, 32'h00100093);                          // addi x1,x0,1
    tick();
    check_eq("bp1_valid", out_valid, 1);
    check_eq("bp1_pc", out_pc, 32'h200);
    check_eq("bp1_in_ready", in_ready, 1);
    offer(32'h204, 32'h00200113);                          // addi x2,x0,2
    tick();
    check_eq("bp2_in_ready", in_ready, 0);
    check_eq("bp2_pc_stable", out_pc, 32'h200);
    offer(32'h208, 32'h00300193);                          // addi x3,x0,3
    tick();
    check_eq("bp3_in_ready", in_ready, 0);
    check_eq("bp3_pc_stable", out_pc, 32'h200);
    check_eq("bp3_rd_stable", out_rd, 1);
    out_ready = 1'b1;
    tick();
    check_eq("bp_out2_pc", out_pc, 32'h204);
    check_eq("bp_out2_rd", out_rd, 2);
    tick();
    check_eq("bp_out3_pc", out_pc, 32'h208);
    check_eq("bp_out3_rd", out_rd, 3);
    in_valid = 1'b0;
    tick();
    check_eq("bp_done_empty", out_valid, 0);

    // Flush in TWO with an offered instruction.
    out_ready = 1'b0;
    offer(32'h300, 32'h00100093);
    tick();
    offer(32'h304, 32'h00200113);
    tick();
    check_eq("fl_two_in_ready", in_ready, 0);
    offer(32'h308, 32'h00300193);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_out_valid", out_valid, 0);
    check_eq("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    check_eq("fl_no_ghost", out_valid, 0);

    // Flush while empty drops an offer that in_ready would have taken.
    offer(32'h30C, 32'h00400213);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_empty_drop", out_valid, 0);

    // Reset mid-stream clears outputs without a clock edge.
    out_ready = 1'b0;
    offer(32'h400, 32'h00500293);
    tick();
    in_valid = 1'b0;
    check_eq("rs_mid_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rs_async_valid", out_valid, 0);
    check_eq("rs_async_pc", out_pc, 0);
    check_eq("rs_async_rd", out_rd, 0);
    check_eq("rs_async_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
